// File: rtl/imem_loader.sv
// Boot-time instruction-memory loader: parses a framed byte stream, writes big-endian
// 16-bit words from address 0 and releases the CPU only after the checksum verifies.
module imem_loader #(
    parameter int          ADDR_W = 8,
    parameter logic [7:0]  MAGIC  = 8'hA5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [15:0]       imem_wdata,
    output logic              cpu_hold,
    output logic              done,
    output logic              error,
    output logic [ADDR_W-1:0] words_loaded
);

    // state   | meaning
    // S_IDLE  | after reset, waiting for start, CPU held
    // S_MAGIC | expecting the magic byte
    // S_LEN   | expecting the word count N
    // S_HI    | expecting high byte of a word
    // S_LO    | expecting low byte of a word, write scheduled on accept
    // S_CSUM  | expecting payload checksum
    // S_DONE  | frame verified, CPU released
    // S_ERR   | frame rejected, CPU held
    typedef enum logic [2:0] {
        S_IDLE, S_MAGIC, S_LEN, S_HI, S_LO, S_CSUM, S_DONE, S_ERR
    } state_t;

    localparam int MAX_N = (2 ** ADDR_W) - 1;

    state_t      state, state_nx;
    logic [7:0]  sum;
    logic [7:0]  len_n;
    logic [7:0]  hi_byte;
    logic        accept;
    logic        last_word;
    logic        len_bad;
    logic        restart;

    assign accept    = in_valid && in_ready;
    assign last_word = (int'(words_loaded) == (int'(len_n) - 1));
    assign len_bad   = (in_data == 8'd0) || (int'(in_data) > MAX_N);
    assign restart   = start && ((state == S_IDLE) || (state == S_DONE) || (state == S_ERR));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= S_IDLE;
        else      state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        in_ready = 1'b0;
        cpu_hold = 1'b1;
        done     = 1'b0;
        error    = 1'b0;
        case (state)
            S_IDLE:  if (start) state_nx = S_MAGIC;
            S_MAGIC: begin
                in_ready = 1'b1;
                if (in_valid) state_nx = (in_data == MAGIC) ? S_LEN : S_ERR;
            end
            S_LEN: begin
                in_ready = 1'b1;
                if (in_valid) state_nx = len_bad ? S_ERR : S_HI;
            end
            S_HI: begin
                in_ready = 1'b1;
                if (in_valid) state_nx = S_LO;
            end
            S_LO: begin
                in_ready = 1'b1;
                if (in_valid) state_nx = last_word ? S_CSUM : S_HI;
            end
            S_CSUM: begin
                in_ready = 1'b1;
                if (in_valid) state_nx = (in_data == sum) ? S_DONE : S_ERR;
            end
            S_DONE: begin
                done     = 1'b1;
                cpu_hold = 1'b0;
                if (start) state_nx = S_MAGIC;
            end
            S_ERR: begin
                error = 1'b1;
                if (start) state_nx = S_MAGIC;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    // Datapath: the write strobe is a registered single-cycle pulse after each LO byte.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sum          <= 8'd0;
            len_n        <= 8'd0;
            hi_byte      <= 8'd0;
            words_loaded <= '0;
            imem_we      <= 1'b0;
            imem_addr    <= '0;
            imem_wdata   <= 16'd0;
        end else begin
            imem_we <= 1'b0;
            if (restart) begin
                sum          <= 8'd0;
                words_loaded <= '0;
            end
            if (accept) begin
                case (state)
                    S_LEN: len_n <= in_data;
                    S_HI: begin
                        hi_byte <= in_data;
                        sum     <= sum + in_data;
                    end
                    S_LO: begin
                        sum          <= sum + in_data;
                        imem_we      <= 1'b1;
                        imem_addr    <= words_loaded;
                        imem_wdata   <= {hi_byte, in_data};
                        words_loaded <= words_loaded + {{(ADDR_W-1){1'b0}}, 1'b1};
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: directed frames plus randomized frames checked
// against an array-level model of the frame format.
module tb_imem_loader;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic        imem_we;
    logic [7:0]  imem_addr;
    logic [15:0] imem_wdata;
    logic        cpu_hold;
    logic        done;
    logic        error;
    logic [7:0]  words_loaded;

    imem_loader #(.ADDR_W(8), .MAGIC(8'hA5)) dut (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .imem_we(imem_we), .imem_addr(imem_addr),
        .imem_wdata(imem_wdata), .cpu_hold(cpu_hold), .done(done), .error(error),
        .words_loaded(words_loaded)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    logic [7:0]  frame[$];
    logic [23:0] exp_writes[$];
    logic [23:0] got_writes[$];
    int          consumed;
    logic        exp_done, exp_err;
    logic [7:0]  exp_wl;

    always @(negedge clk) if (imem_we) got_writes.push_back({imem_addr, imem_wdata});

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Frame semantics from the format: magic, count, N word pairs, mod-256 payload sum.
    task automatic model_frame();
        int n, s;
        exp_writes.delete();
        exp_done = 1'b0; exp_err = 1'b0; exp_wl = 8'd0;
        if (frame[0] != 8'hA5) begin
            consumed = 1; exp_err = 1'b1;
        end else if (frame[1] == 8'd0) begin
            consumed = 2; exp_err = 1'b1;
        end else begin
            n = int'(frame[1]); s = 0;
            for (int i = 0; i < n; i++) begin
                exp_writes.push_back({i[7:0], frame[2+2*i], frame[3+2*i]});
                s += int'(frame[2+2*i]) + int'(frame[3+2*i]);
            end
            consumed = 2*n + 3;
            exp_wl   = n[7:0];
            if (int'(frame[2+2*n]) == (s % 256)) exp_done = 1'b1;
            else                                 exp_err  = 1'b1;
        end
    endtask

    task automatic set_good_frame();
        logic [7:0] g[$] = '{8'hA5, 8'h03, 8'h10, 8'h01, 8'h20, 8'h02, 8'h70, 8'h00, 8'hA3};
        frame = g;
    endtask

    // gaps: 0 full rate, 1 alternate idle cycles, 2 random idle cycles
    task automatic run_frame(input int gaps, input bit do_start, input int start_at);
        int t;
        model_frame();
        got_writes.delete();
        if (do_start) begin
            start = 1'b1; @(negedge clk); start = 1'b0;
            chk("ready_after_start", in_ready, 1);
            chk("hold_during_load", cpu_hold, 1);
            chk("done_clear_on_start", done, 0);
            chk("error_clear_on_start", error, 0);
        end
        for (int i = 0; i < consumed; i++) begin
            if (i > 0 && (gaps == 1 || (gaps == 2 && $urandom_range(0, 1) == 1))) begin
                in_valid = 1'b0;
                @(negedge clk);
                chk("ready_in_gap", in_ready, 1);
            end
            in_valid = 1'b1;
            in_data  = frame[i];
            if (i == start_at) start = 1'b1;
            t = 0;
            while (!in_ready && t < 20) begin @(negedge clk); t++; end
            if (t == 20) chk("handshake_timeout", in_ready, 1);
            @(negedge clk);
            start = 1'b0;
        end
        in_valid = 1'b0;
        chk("done", done, exp_done);
        chk("error", error, exp_err);
        chk("cpu_hold", cpu_hold, !exp_done);
        chk("ready_after_frame", in_ready, 0);
        chk("words_loaded", words_loaded, exp_wl);
        repeat (2) @(negedge clk);
        chk("write_count", got_writes.size(), exp_writes.size());
        for (int i = 0; i < exp_writes.size() && i < got_writes.size(); i++)
            chk("write_addr_data", got_writes[i], exp_writes[i]);
        chk("done_stable", done, exp_done);
    endtask

    initial begin
        logic [7:0] b;
        int n, kind, s, gaps, sat;
        rst = 1'b0; start = 1'b0; in_valid = 1'b0; in_data = 8'd0;
        repeat (2) @(negedge clk);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_imem_we", imem_we, 0);
        chk("rst_imem_addr", imem_addr, 0);
        chk("rst_imem_wdata", imem_wdata, 0);
        chk("rst_cpu_hold", cpu_hold, 1);
        chk("rst_done", done, 0);
        chk("rst_error", error, 0);
        chk("rst_words_loaded", words_loaded, 0);
        rst = 1'b1;
        @(negedge clk);

        set_good_frame(); run_frame(0, 1, -1);
        set_good_frame(); run_frame(1, 1, -1);

        frame = '{8'h5A, 8'h03};
        run_frame(0, 1, -1);
        chk("bad_magic_no_write", got_writes.size(), 0);
        set_good_frame(); run_frame(0, 1, -1);

        set_good_frame(); frame[8] = 8'hA4; run_frame(0, 1, -1);
        frame = '{8'hA5, 8'h00}; run_frame(0, 1, -1);

        // Reset in the middle of a frame, right as the second word is written.
        set_good_frame();
        start = 1'b1; @(negedge clk); start = 1'b0;
        for (int i = 0; i < 6; i++) begin
            in_valid = 1'b1; in_data = frame[i]; @(negedge clk);
        end
        in_valid = 1'b0;
        chk("mid_we_before_reset", imem_we, 1);
        rst = 1'b0; #1;
        chk("mid_rst_in_ready", in_ready, 0);
        chk("mid_rst_imem_we", imem_we, 0);
        chk("mid_rst_imem_addr", imem_addr, 0);
        chk("mid_rst_imem_wdata", imem_wdata, 0);
        chk("mid_rst_cpu_hold", cpu_hold, 1);
        chk("mid_rst_done", done, 0);
        chk("mid_rst_error", error, 0);
        chk("mid_rst_words_loaded", words_loaded, 0);
        @(negedge clk); rst = 1'b1; @(negedge clk);
        set_good_frame(); run_frame(0, 1, -1);

        // start ignored mid-frame, then honoured in DONE.
        set_good_frame(); run_frame(0, 1, 4);
        start = 1'b1; @(negedge clk); start = 1'b0;
        chk("restart_hold", cpu_hold, 1);
        chk("restart_done", done, 0);
        chk("restart_ready", in_ready, 1);
        chk("restart_words", words_loaded, 0);
        set_good_frame(); run_frame(2, 0, -1);

        // Largest legal frame.
        frame.delete(); frame.push_back(8'hA5); frame.push_back(8'hFF); s = 0;
        for (int i = 0; i < 510; i++) begin
            b = 8'($urandom_range(0, 255)); frame.push_back(b); s += int'(b);
        end
        frame.push_back(8'(s % 256));
        run_frame(0, 1, -1);

        for (int k = 0; k < 25; k++) begin
            n = $urandom_range(1, 6);
            kind = $urandom_range(0, 9);
            frame.delete(); frame.push_back(8'hA5); frame.push_back(8'(n)); s = 0;
            for (int i = 0; i < 2*n; i++) begin
                b = 8'($urandom_range(0, 255)); frame.push_back(b); s += int'(b);
            end
            frame.push_back(8'(s % 256));
            if (kind == 0) frame[0] = 8'hA5 ^ 8'($urandom_range(1, 255));
            if (kind == 1) frame[1] = 8'h00;
            if (kind == 2 || kind == 3) frame[2*n+2] = frame[2*n+2] + 8'($urandom_range(1, 255));
            gaps = $urandom_range(0, 2);
            sat  = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 2*n) : -1;
            run_frame(gaps, 1, sat);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/imem_loader.md
# imem_loader

Boot-time program loader that sits directly upstream of the CPU's instruction memory. It accepts a framed byte stream over a valid/ready handshake, assembles big-endian 16-bit instruction words and writes them sequentially into instruction memory from address 0. It holds the CPU in reset until a frame is loaded and its checksum verifies. Only then does it release the core.

## Interface
- ADDR_W, 8, instruction-memory address width; frame may carry at most 2^ADDR_W - 1 words (length byte is 8 bits)
- MAGIC, 8'hA5, required first byte of every frame
- clk  input  1  system clock, all logic on rising edge
- rst  input  1  asynchronous, active-low reset
- start  input  1  one-cycle pulse; begins a new load (honoured only in IDLE, DONE, ERR)
- in_valid  input  1  byte available on in_data
- in_data  input  8  stream byte
- in_ready  output  1  loader accepts a byte this cycle
- imem_we  output  1  instruction-memory write strobe
- imem_addr  output  ADDR_W  write address
- imem_wdata  output  16  write data, {high byte, low byte}
- cpu_hold  output  1  1 = CPU held in reset
- done  output  1  frame loaded and verified
- error  output  1  frame rejected
- words_loaded  output  ADDR_W  count of words written in current/last frame

## Operation
- Frame: MAGIC, N (word count), N×(high byte, low byte), CSUM; CSUM = 8-bit modulo-256 sum of all 2N payload bytes (magic and N excluded).
- Byte transfer: in_valid && in_ready on a rising edge. in_ready depends only on state (no combinational path from in_valid).
- States: IDLE, MAGIC, LEN, HI, LO, CSUM, DONE, ERR.
- IDLE: in_ready=0, cpu_hold=1. start → MAGIC; clears sum, words_loaded, done, error.
- MAGIC: accepted byte == MAGIC → LEN, else → ERR.
- LEN: N==0 or N > 2^ADDR_W-1 → ERR; else latch N → HI.
- HI: latch byte, sum += byte → LO.
- LO: sum += byte; schedule write of {hi, byte} at address words_loaded; words_loaded++; if words_loaded (pre-increment) == N-1 → CSUM else → HI.
- CSUM: byte == sum → DONE, else → ERR.
- DONE: done=1, cpu_hold=0, in_ready=0; stays until start.
- ERR: error=1, cpu_hold=1, in_ready=0; stays until start. Words already written are not rolled back.
- start in MAGIC..CSUM ignored. start in DONE re-asserts cpu_hold on the next cycle and reloads.
- in_ready=1 exactly in MAGIC, LEN, HI, LO, CSUM.

## Timing
- Reset values: state=IDLE, in_ready=0, imem_we=0, imem_addr=0, imem_wdata=0, cpu_hold=1, done=0, error=0, words_loaded=0, sum=0.
- Reset mid-frame: immediate return to IDLE with the values above; CPU stays held.
- Accepting one byte per cycle is sustained, with no bubbles. Gaps in in_valid stall the FSM with no state change.
- imem_we is registered. It is high for exactly one cycle, the cycle after the LO byte is accepted, with imem_addr/imem_wdata valid in that same cycle.
- The done=1/cpu_hold=0 transition happens on the edge that accepts a correct CSUM byte. This is one cycle after the last imem_we, so the last write lands before the CPU leaves reset.
- error asserts on the edge that accepts the offending byte.
- Sum wraps modulo 256. words_loaded never exceeds N.
- start → in_ready=1 on the following cycle.
- Minimum frame time from start: 2N+3 accepted bytes, plus 1 cycle of start latency.

## Test plan
- Good frame A5,03,10,01,20,02,70,00,A3 at full rate → writes 0x1001@0, 0x2002@1, 0x7000@2; done=1, cpu_hold=0, words_loaded=3, error=0.
- Same frame with in_valid low every other cycle → identical writes and result. in_ready=1 throughout the load, and no extra or duplicate imem_we pulses occur.
- Bad magic 5A → error=1 on that edge, no imem_we, cpu_hold=1, in_ready=0. A later start plus the good frame gives done=1.
- Bad checksum (last byte A4) → three writes occur, then error=1, done=0, cpu_hold=1. Length byte 00 → error=1 with no writes.
- rst low after the second word byte pair → all outputs return to reset values at once. A start plus a full frame then loads from address 0.
- start pulsed mid-frame → ignored, frame completes normally. start in DONE → cpu_hold=1 the next cycle, done=0, and a new frame loads.
